ctrl_unit: RTL
==============

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_o  out  1  instruction fetch request.
REQ-005 SHALL have port imem_addr_o  out  32  fetch address (current PC).
REQ-006 SHALL have port imem_ack_i  in  1  fetch acknowledge; imem_rdata_i is valid in the same cycle.
REQ-007 SHALL have port imem_rdata_i  in  32  fetched instruction word.
REQ-008 SHALL have ports rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  register-file addresses.
REQ-009 SHALL have port rd_we_o  out  1  register-file write enable; ALU result is written.
REQ-010 SHALL have port alu_sel_o  out  1  ALU operand-B select; 1 = immediate, 0 = rs2.
REQ-011 SHALL have port alu_fun_o  out  4  ALU function code.
REQ-012 SHALL have port imm_ext_o  out  32  sign-extended I-type immediate.
REQ-013 SHALL have port illegal_o  out  1  high while trapped on an unsupported instruction.

Function
REQ-014 SHALL implement FSM states FETCH, DECODE, EXECUTE, WRITEBACK, TRAP.
REQ-015 FETCH: imem_req_o = 1 and imem_addr_o = PC, both held stable until imem_ack_i; on ack, latch imem_rdata_i into IR and go to DECODE.
REQ-016 DECODE: drive rs1 = IR[19:15], rs2 = IR[24:20], rd = IR[11:7]; register alu_sel_o, alu_fun_o, imm_ext_o; go to EXECUTE, or to TRAP if illegal.
REQ-017 R-type, opcode 0110011, alu_sel = 0: ADD (f3 000, f7 0000000) -> 0000; SUB (000/0100000) -> 0001; AND (111/0000000) -> 0010; XOR (100/0000000) -> 0011; OR (110/0000000) -> 0100.
REQ-018 I-type, opcode 0010011, alu_sel = 1: ADDI f3 000 -> 0000; ANDI 111 -> 0010; XORI 100 -> 0011; ORI 110 -> 0100.
REQ-019 imm_ext_o SHALL be IR[31:20] sign-extended to 32 bits.
REQ-020 Any other opcode/funct3/funct7 combination SHALL be illegal.
REQ-021 alu_sel_o, alu_fun_o, imm_ext_o and the register addresses SHALL stay stable from the cycle after DECODE through WRITEBACK.
REQ-022 EXECUTE SHALL last exactly one cycle and then go to WRITEBACK.
REQ-023 WRITEBACK SHALL last one cycle with rd_we_o = 1, except when rd = 0, where rd_we_o stays 0.
REQ-024 WRITEBACK SHALL set PC to PC + 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0), and then go to FETCH.
REQ-025 rd_we_o SHALL be 0 in every state except WRITEBACK.
REQ-026 Each instruction SHALL retire in 4 cycles when ack arrives in the first FETCH cycle; each cycle of ack delay adds one cycle.
REQ-027 TRAP: illegal_o = 1, imem_req_o = 0, rd_we_o = 0; the block SHALL stay in TRAP until reset.

Reset
REQ-028 While rst_ni = 0, the block SHALL asynchronously force state = FETCH, PC = RESET_PC, IR = 0 and all outputs to 0.
REQ-029 imem_req_o SHALL assert in the first cycle after rst_ni deasserts.
REQ-030 Reset in any state, including mid-fetch, SHALL abandon the operation and raise no rd_we_o.

Structure
REQ-031 Package ceviz_pkg SHALL hold the opcode constants, the ALU function codes (shared with the ALU) and the FSM state enum.
REQ-032 Sub-module ctrl_decoder SHALL contain the combinational IR -> {alu_sel, alu_fun, imm_ext, illegal} decoding; ctrl_unit instantiates it.

Verification
REQ-033 Reset, then ack 0x00500093 (ADDI x1,x0,5) immediately -> addr 0; EXECUTE: alu_sel=1, fun=0000, imm=5; WRITEBACK: rd=1, we=1; next fetch addr 4.
REQ-034 0x402081B3 (SUB x3,x1,x2) -> alu_sel=0, fun=0001, rs1=1, rs2=2, rd=3, we=1 in WRITEBACK.
REQ-035 Delay ack by 3 cycles -> req and addr held stable 4 cycles; retire in 7 cycles.
REQ-036 0xFFF0F093 (ANDI x1,x1,-1) -> imm_ext=32'hFFFF_FFFF, fun=0010; then 0xFFFFFFFF -> illegal_o=1, req=0, no we, held for 20 cycles.
REQ-037 0x00100013 (ADDI x0,x0,1) -> rd_we_o stays 0; PC still advances by 4.
REQ-038 Assert rst_ni low mid-EXECUTE -> all outputs 0 immediately; after release, fetch at RESET_PC.

Source files
------------

// File: rtl/ceviz_pkg.sv
// Shared constants for the ceviz core: opcodes, ALU function codes and
// the control FSM state encoding.
package ceviz_pkg;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_TRAP
  } state_t;

  typedef struct packed {
    logic        alu_sel;
    logic [3:0]  alu_fun;
    logic [31:0] imm_ext;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational instruction decode: ALU operand select, function code,
// sign-extended I-immediate and the illegal-instruction flag.
module ctrl_decoder
  import ceviz_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm12,
  output dec_t        dec
);

  always_comb begin
    dec         = '0;
    dec.imm_ext = {{20{imm12[11]}}, imm12};
    dec.illegal = 1'b1;
    case (opcode)
      OP_R: begin
        dec.alu_sel = 1'b0;
        case ({funct7, funct3})
          10'b0000000_000: begin dec.alu_fun = ALU_ADD; dec.illegal = 1'b0; end
          10'b0100000_000: begin dec.alu_fun = ALU_SUB; dec.illegal = 1'b0; end
          10'b0000000_111: begin dec.alu_fun = ALU_AND; dec.illegal = 1'b0; end
          10'b0000000_100: begin dec.alu_fun = ALU_XOR; dec.illegal = 1'b0; end
          10'b0000000_110: begin dec.alu_fun = ALU_OR;  dec.illegal = 1'b0; end
          default: ;
        endcase
      end
      OP_I: begin
        dec.alu_sel = 1'b1;
        // funct7 overlaps the immediate for I-type, so only funct3 matters
        case (funct3)
          3'b000: begin dec.alu_fun = ALU_ADD; dec.illegal = 1'b0; end
          3'b111: begin dec.alu_fun = ALU_AND; dec.illegal = 1'b0; end
          3'b100: begin dec.alu_fun = ALU_XOR; dec.illegal = 1'b0; end
          3'b110: begin dec.alu_fun = ALU_OR;  dec.illegal = 1'b0; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multi-cycle control unit: FETCH -> DECODE -> EXECUTE -> WRITEBACK,
// with a sticky TRAP state on unsupported instructions.
module ctrl_unit
  import ceviz_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_we_o,
  output logic        alu_sel_o,
  output logic [3:0]  alu_fun_o,
  output logic [31:0] imm_ext_o,
  output logic        illegal_o
);

  state_t      state, state_nxt;
  logic [31:0] pc, ir;
  dec_t        dec, ctrl;

  ctrl_decoder u_dec (
    .opcode (ir[6:0]),
    .funct3 (ir[14:12]),
    .funct7 (ir[31:25]),
    .imm12  (ir[31:20]),
    .dec    (dec)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_FETCH;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:     if (imem_ack_i) state_nxt = S_DECODE;
      S_DECODE:    state_nxt = dec.illegal ? S_TRAP : S_EXECUTE;
      S_EXECUTE:   state_nxt = S_WRITEBACK;
      S_WRITEBACK: state_nxt = S_FETCH;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_FETCH;
    endcase
  end

  // Decoded controls are captured once so they hold through WRITEBACK.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc   <= RESET_PC;
      ir   <= '0;
      ctrl <= '0;
    end else begin
      if (state == S_FETCH && imem_ack_i) ir <= imem_rdata_i;
      if (state == S_DECODE)              ctrl <= dec;
      if (state == S_WRITEBACK)           pc <= pc + 32'd4;
    end
  end

  // Reset gating keeps the fetch port quiet while rst_ni is low, even
  // though the state register already sits in FETCH.
  assign imem_req_o  = rst_ni && (state == S_FETCH);
  assign imem_addr_o = rst_ni ? pc : '0;
  assign rs1_addr_o  = ir[19:15];
  assign rs2_addr_o  = ir[24:20];
  assign rd_addr_o   = ir[11:7];
  assign rd_we_o     = (state == S_WRITEBACK) && (ir[11:7] != 5'd0);
  assign alu_sel_o   = ctrl.alu_sel;
  assign alu_fun_o   = ctrl.alu_fun;
  assign imm_ext_o   = ctrl.imm_ext;
  assign illegal_o   = (state == S_TRAP);

endmodule
